gather: RTL and testbench
=========================

Name: gather

Overview:
- Downstream consumer of the reorder stage.
- Takes the ordered stream of {index, data} words and rebuilds one N-wide parallel vector per frame.
- Presents that vector on a single strobe/ready output for the next layer of the datapath.
- Checks index sequencing and reports any gap or out-of-range index with the frame it belongs to.

Parameters:
- W, 8, data width of one element.
- N, 2, elements per frame; N >= 2 (index width is $clog2(N), which must be nonzero).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- s_stb  input  1  input word valid.
- s_dat  input  $clog2(N)+W  {index, data}; index in the upper $clog2(N) bits, data in the low W bits.
- s_rdy  output  1  input word accepted when s_stb & s_rdy.
- m_stb  output  1  assembled frame valid.
- m_dat  output  N*W  frame; element k in bits [k*W +: W].
- m_err  output  1  frame sequencing error; meaningful only while m_stb=1.
- m_rdy  input  1  frame consumed when m_stb & m_rdy.

Behaviour:
- Reset (rst=0 at posedge):
  - m_stb=0, m_err=0, m_dat=0.
  - Expected index exp=0, error accumulator err_acc=0, state COLLECT.
  - Reset mid-frame discards all partially collected elements.
- States: COLLECT and FULL.
- s_rdy = 1 in COLLECT, 0 in FULL. It is combinational from state only and never depends on s_stb.
- COLLECT, on each accepted word with index a and data d:
  - If a < N: write d into slot a of m_dat. All other slots are unchanged.
  - If a >= N (only possible when N is not a power of 2): data is dropped, err_acc <= 1, no slot is written, and the frame does not complete.
  - If a != exp: err_acc <= 1.
  - exp <= a+1, resyncing to the stream. If a == N-1, exp <= 0.
  - If a == N-1: go to FULL, m_stb <= 1, m_err <= err_acc | (a != exp).
- Latency: m_stb rises in the cycle after the index N-1 word is accepted. A frame takes at least N+1 cycles when m_rdy is held high.
- FULL:
  - m_dat and m_err stay stable while m_stb=1 and m_rdy=0.
  - On m_stb & m_rdy: m_stb <= 0, m_err <= 0, err_acc <= 0, state COLLECT, exp stays 0.
  - m_dat keeps its old contents. Slots not rewritten in the next frame carry stale data, and m_err flags this case.
- No skid or double buffer. A new word may be accepted only from the cycle after the frame handshake.
- Simultaneous events:
  - s_stb while in FULL is ignored (s_rdy=0); the upstream word is held.
  - rst=0 takes priority over every handshake in the same cycle.
- Index wrap: the index N-1 to 0 boundary marks the frame end.
  - A stream that skips index N-1 (e.g. 0,1,0 for N=3) never completes a frame.
  - Such a stream keeps setting err_acc on every out-of-sequence word.
  - This is intentional: the frame ends only at index N-1.
- Output m_stb must not depend combinationally on m_rdy. m_dat, m_stb and m_err are all registered.

Test Plan:
- W=8, N=4, m_rdy=1: send {0,0x11},{1,0x22},{2,0x33},{3,0x44} back-to-back → m_stb=1 one cycle after the 4th accept, m_dat=0x44332211, m_err=0; s_rdy=0 for exactly that cycle.
- Backpressure, m_rdy=0 for 10 cycles after a full frame → m_stb, m_dat and m_err held constant; s_rdy=0 throughout; the first word of frame 2 is accepted only after the m_stb&m_rdy cycle.
- Gap, N=4: indices 0,1,3 with data 0xA0,0xA1,0xA3, after a prior frame 0x44332211 → frame completes with m_dat=0xA333A1A0 (slot 2 stale 0x33) and m_err=1. The next clean frame has m_err=0.
- Out-of-range, N=3 (2-bit index): send {3,0xFF} then 0,1,2 with 0x01,0x02,0x03 → 0xFF is never written; frame m_dat=0x030201, m_err=1.
- Reset mid-frame: accept indices 0,1, then pulse rst=0 for one cycle → m_stb=0, m_dat=0; resending 0..3 yields a clean frame with m_err=0.
- Random stall soak, N=4: random s_stb and m_rdy over 1000 frames with in-order indices → every frame matches the scoreboard, m_err never asserts, and no word is lost or duplicated.

Source files
------------

// File: rtl/gather.sv
// Rebuilds one N-wide parallel frame from an ordered {index, data} stream.
// Flags index gaps and out-of-range indices on the frame they belong to.
module gather #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_stb,
  input  logic [$clog2(N)+W-1:0]  s_dat,
  output logic                    s_rdy,
  output logic                    m_stb,
  output logic [N*W-1:0]          m_dat,
  output logic                    m_err,
  input  logic                    m_rdy
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0]   NLIM = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t         r_state, w_state;
  logic [IW-1:0]  r_exp, w_exp;
  logic           r_acc, w_acc;
  logic           r_stb, w_stb;
  logic           r_err, w_err;
  logic [N*W-1:0] r_dat, w_dat;

  logic [IW-1:0]  w_idx;
  logic [W-1:0]   w_d;
  logic           w_take;
  logic           w_inr;
  logic           w_last;
  logic           w_miss;

  assign w_idx  = s_dat[W +: IW];
  assign w_d    = s_dat[W-1:0];
  assign s_rdy  = (r_state == COLLECT);
  assign w_take = s_stb & s_rdy;
  assign w_inr  = {1'b0, w_idx} < NLIM;
  assign w_last = (w_idx == LAST);
  assign w_miss = (w_idx != r_exp);

  always_comb begin
    w_state = r_state;
    w_exp   = r_exp;
    w_acc   = r_acc;
    w_stb   = r_stb;
    w_err   = r_err;
    w_dat   = r_dat;
    unique case (r_state)
      COLLECT: begin
        if (w_take) begin
          if (w_inr) begin
            w_dat[w_idx*W +: W] = w_d;
          end
          if (!w_inr || w_miss) begin
            w_acc = 1'b1;
          end
          // Resync to whatever index arrived.
          w_exp = w_idx + 1'b1;
          if (w_last) begin
            w_exp   = '0;
            w_state = FULL;
            w_stb   = 1'b1;
            w_err   = r_acc | w_miss;
          end
        end
      end
      FULL: begin
        if (m_rdy) begin
          w_state = COLLECT;
          w_stb   = 1'b0;
          w_err   = 1'b0;
          w_acc   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= COLLECT;
      r_exp   <= '0;
      r_acc   <= 1'b0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state;
      r_exp   <= w_exp;
      r_acc   <= w_acc;
      r_stb   <= w_stb;
      r_err   <= w_err;
      r_dat   <= w_dat;
    end
  end

  assign m_stb = r_stb;
  assign m_err = r_err;
  assign m_dat = r_dat;

endmodule

// File: tb/tb_gather.sv
// Scoreboard bench for gather: N=4 instance for most tests,
// N=3 instance for the out-of-range index case.
module tb_gather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_stb4, s_rdy4, m_stb4, m_err4, m_rdy4;
  logic [9:0]  s_dat4;
  logic [31:0] m_dat4;
  logic        s_stb3, s_rdy3, m_stb3, m_err3, m_rdy3;
  logic [9:0]  s_dat3;
  logic [23:0] m_dat3;

  gather #(.W(8), .N(4)) u4 (
    .clk(clk), .rst(rst),
    .s_stb(s_stb4), .s_dat(s_dat4), .s_rdy(s_rdy4),
    .m_stb(m_stb4), .m_dat(m_dat4), .m_err(m_err4), .m_rdy(m_rdy4)
  );

  gather #(.W(8), .N(3)) u3 (
    .clk(clk), .rst(rst),
    .s_stb(s_stb3), .s_dat(s_dat3), .s_rdy(s_rdy3),
    .m_stb(m_stb3), .m_dat(m_dat3), .m_err(m_err3), .m_rdy(m_rdy3)
  );

  typedef struct {
    logic [31:0] dat;
    bit          err;
  } frm_t;

  frm_t q0[$];
  frm_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: frame contents persist, error sticks until frame end.
  logic [7:0] sl[2][4];
  bit         me[2];
  int         mx[2];

  function automatic void mreset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) sl[d][k] = 8'h00;
      me[d] = 1'b0;
      mx[d] = 0;
    end
  endfunction

  function automatic void model(int d, int n, int idx, int dat);
    frm_t f;
    if (idx < n) sl[d][idx] = dat[7:0];
    else me[d] = 1'b1;
    if (idx != mx[d]) me[d] = 1'b1;
    mx[d] = (idx + 1) % 4;
    if (idx == n - 1) begin
      f.dat = '0;
      for (int k = 0; k < n; k++) f.dat[k*8 +: 8] = sl[d][k];
      f.err = me[d];
      if (d == 0) q0.push_back(f);
      else q1.push_back(f);
      me[d] = 1'b0;
      mx[d] = 0;
    end
  endfunction

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always begin : mon4
    frm_t f;
    @(negedge clk);
    #2;
    if (rst && m_stb4 && m_rdy4) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame4_extra: got %h expected no frame", m_dat4);
      end else begin
        f = q0.pop_front();
        check("frame4_dat", m_dat4, f.dat);
        check("frame4_err", 32'(m_err4), 32'(f.err));
      end
    end
  end

  always begin : mon3
    frm_t f;
    @(negedge clk);
    #2;
    if (rst && m_stb3 && m_rdy3) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame3_extra: got %h expected no frame", m_dat3);
      end else begin
        f = q1.pop_front();
        check("frame3_dat", 32'(m_dat3), f.dat);
        check("frame3_err", 32'(m_err3), 32'(f.err));
      end
    end
  end

  task automatic send4(int idx, int dat, bit soak);
    int g;
    bit done;
    g = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (soak) m_rdy4 = 1'($urandom_range(0, 1));
      if (soak && $urandom_range(0, 3) == 0) begin
        s_stb4 = 1'b0;
      end else begin
        s_stb4 = 1'b1;
        s_dat4 = {2'(idx), 8'(dat)};
        if (s_rdy4) begin
          model(0, 4, idx, dat);
          done = 1'b1;
        end
      end
      g++;
      if (!done && g > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send4_timeout: got no accept expected accept idx %0d", idx);
        done = 1'b1;
      end
    end
  endtask

  task automatic send3(int idx, int dat);
    int g;
    bit done;
    g = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      s_stb3 = 1'b1;
      s_dat3 = {2'(idx), 8'(dat)};
      if (s_rdy3) begin
        model(1, 3, idx, dat);
        done = 1'b1;
      end
      g++;
      if (!done && g > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send3_timeout: got no accept expected accept idx %0d", idx);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(int c);
    repeat (c) begin
      @(negedge clk);
      s_stb4 = 1'b0;
      s_stb3 = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b0;
    s_stb4 = 1'b0;
    s_stb3 = 1'b0;
    s_dat4 = '0;
    s_dat3 = '0;
    m_rdy4 = 1'b1;
    m_rdy3 = 1'b1;
    mreset();
    repeat (2) @(negedge clk);
    check("rst_m_stb", 32'(m_stb4), 32'd0);
    check("rst_m_err", 32'(m_err4), 32'd0);
    check("rst_m_dat", m_dat4, 32'h0);
    check("rst_s_rdy", 32'(s_rdy4), 32'd1);
    check("rst_m_dat3", 32'(m_dat3), 32'h0);
    rst = 1'b1;

    // Back-to-back frame, m_rdy high.
    send4(0, 8'h11, 1'b0);
    send4(1, 8'h22, 1'b0);
    send4(2, 8'h33, 1'b0);
    send4(3, 8'h44, 1'b0);
    idle(1);
    check("lat_m_stb", 32'(m_stb4), 32'd1);
    check("lat_s_rdy", 32'(s_rdy4), 32'd0);
    check("lat_m_dat", m_dat4, 32'h44332211);
    check("lat_m_err", 32'(m_err4), 32'd0);
    idle(1);
    check("post_m_stb", 32'(m_stb4), 32'd0);
    check("post_s_rdy", 32'(s_rdy4), 32'd1);

    // Backpressure for 10 cycles.
    m_rdy4 = 1'b0;
    send4(0, 8'h11, 1'b0);
    send4(1, 8'h22, 1'b0);
    send4(2, 8'h33, 1'b0);
    send4(3, 8'h44, 1'b0);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("bp_m_stb", 32'(m_stb4), 32'd1);
      check("bp_s_rdy", 32'(s_rdy4), 32'd0);
      check("bp_m_dat", m_dat4, 32'h44332211);
      check("bp_m_err", 32'(m_err4), 32'd0);
    end
    @(negedge clk);
    s_stb4 = 1'b1;
    s_dat4 = {2'd0, 8'h11};
    check("bp_word_held", 32'(s_rdy4), 32'd0);
    m_rdy4 = 1'b1;
    send4(0, 8'h11, 1'b0);
    send4(1, 8'h22, 1'b0);
    send4(2, 8'h33, 1'b0);
    send4(3, 8'h44, 1'b0);
    idle(2);

    // Gap: slot 2 keeps stale data.
    send4(0, 8'hA0, 1'b0);
    send4(1, 8'hA1, 1'b0);
    send4(3, 8'hA3, 1'b0);
    idle(1);
    check("gap_m_dat", m_dat4, 32'hA333A1A0);
    check("gap_m_err", 32'(m_err4), 32'd1);
    idle(1);
    for (int i = 0; i < 4; i++) send4(i, int'($urandom_range(0, 255)), 1'b0);
    idle(1);
    check("clean_m_err", 32'(m_err4), 32'd0);
    idle(1);

    // Reset mid-frame.
    send4(0, 8'h5A, 1'b0);
    send4(1, 8'h5B, 1'b0);
    @(negedge clk);
    s_stb4 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mreset();
    check("mrst_m_stb", 32'(m_stb4), 32'd0);
    check("mrst_m_dat", m_dat4, 32'h0);
    check("mrst_s_rdy", 32'(s_rdy4), 32'd1);
    send4(0, 8'h01, 1'b0);
    send4(1, 8'h02, 1'b0);
    send4(2, 8'h03, 1'b0);
    send4(3, 8'h04, 1'b0);
    idle(1);
    check("mrst_m_err", 32'(m_err4), 32'd0);
    idle(1);

    // Out-of-range index on N=3.
    send3(3, 8'hFF);
    send3(0, 8'h01);
    send3(1, 8'h02);
    send3(2, 8'h03);
    idle(1);
    check("oor_m_dat", 32'(m_dat3), 32'h030201);
    check("oor_m_err", 32'(m_err3), 32'd1);
    idle(2);

    // Random stall soak.
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 4; i++) send4(i, int'($urandom_range(0, 255)), 1'b1);
    end
    idle(1);
    m_rdy4 = 1'b1;
    idle(5);
    check("q_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
